// File: rtl/z16_instr_loader.sv
// rtl/z16_instr_loader.sv - byte-stream loader that fills the Z16 instruction store
// Optional checksum trailer byte is enabled with `define Z16_LOADER_CHECKSUM_EN.
module z16_instr_loader #(
  parameter int DEPTH_WORDS = 16,
  parameter int LEN_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  input  logic             i_reload,
  output logic             o_wr_en,
  output logic [15:0]      o_wr_addr,
  output logic [15:0]      o_wr_data,
  output logic             o_cpu_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_word_count
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_DONE,
    S_ERROR
`ifdef Z16_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t           r_state;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_lo;
  logic [LEN_W-1:0] r_word_count;
  logic             r_wr_en;
  logic [15:0]      r_wr_addr;
  logic [15:0]      r_wr_data;
  logic             r_cpu_rst;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
`ifdef Z16_LOADER_CHECKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic             w_accept;
  logic [LEN_W-1:0] w_len_hdr;
  logic [LEN_W-1:0] w_count_next;

  // Ready depends on state alone so the upstream receiver never sees a combinational path back.
  assign o_rx_ready   = (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_accept     = i_rx_valid && o_rx_ready;
  assign w_len_hdr    = LEN_W'({i_rx_data, r_len_lo});
  assign w_count_next = r_word_count + LEN_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_LEN_LO;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_lo         <= '0;
      r_word_count <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef Z16_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_LEN_LO: begin
`ifdef Z16_LOADER_CHECKSUM_EN
          r_sum <= '0;
`endif
          if (w_accept) begin
            r_len_lo <= i_rx_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len_hdr;
            if (w_len_hdr > LEN_W'(DEPTH_WORDS)) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_len_hdr == '0) begin
`ifdef Z16_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_lo    <= i_rx_data;
            r_state <= S_DATA_HI;
`ifdef Z16_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + i_rx_data;
`endif
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_wr_en      <= 1'b1;
            r_wr_data    <= {i_rx_data, r_lo};
            r_wr_addr    <= 16'({r_word_count, 1'b0});
            r_word_count <= w_count_next;
`ifdef Z16_LOADER_CHECKSUM_EN
            r_sum        <= r_sum + i_rx_data;
`endif
            if (w_count_next == r_len) begin
`ifdef Z16_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA_LO;
            end
          end
        end
`ifdef Z16_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_busy <= 1'b0;
            if (i_rx_data == r_sum) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERROR: begin
          // Old image stays in memory; only the bookkeeping restarts.
          if (i_reload) begin
            r_state      <= S_LEN_LO;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        default: r_state <= S_LEN_LO;
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_z16_instr_loader.sv
// tb/tb_z16_instr_loader.sv - directed self-checking bench for z16_instr_loader
module tb_z16_instr_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        i_reload;
  logic        o_wr_en;
  logic [15:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_cpu_rst;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_word_count;

  int errors = 0;
  int checks = 0;
  int consec = 0;
  logic prev_wr_en = 1'b0;
  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];

  z16_instr_loader #(.DEPTH_WORDS(16), .LEN_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready), .i_reload(i_reload), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_cpu_rst(o_cpu_rst), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // Write log and back-to-back strobe watch, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      wq_addr.push_back(o_wr_addr);
      wq_data.push_back(o_wr_data);
    end
    if (o_wr_en && prev_wr_en) consec++;
    prev_wr_en = o_wr_en;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
  endtask

  task automatic clear_log();
    tick();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", o_rx_ready); end
    checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== 33'd0) begin errors++; $display("FAIL reset_wr got=%0h exp=0", {o_wr_en, o_wr_addr, o_wr_data}); end
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b1100) begin errors++; $display("FAIL reset_flags got=%b exp=1100", {o_cpu_rst, o_busy, o_done, o_err}); end
    checks++; if (o_word_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_word_count); end
  endtask

  task automatic test_two_word();
    send(8'h02); send(8'h00); send(8'h10); send(8'h00);
    checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 16'h0000, 16'h0010}) begin errors++; $display("FAIL two_word_w0 got=%0h exp=%0h", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 16'h0000, 16'h0010}); end
    send(8'h19);
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL two_word_strobe_len got=%0h exp=0", o_wr_en); end
    checks++; if (o_wr_data !== 16'h0010) begin errors++; $display("FAIL two_word_hold got=%0h exp=0010", o_wr_data); end
    send(8'h01);
    checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 16'h0002, 16'h0119}) begin errors++; $display("FAIL two_word_w1 got=%0h exp=%0h", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 16'h0002, 16'h0119}); end
`ifdef Z16_LOADER_CHECKSUM_EN
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL two_word_chk_wait got=%0h exp=0", o_done); end
    send(8'h2A);
`endif
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b0010) begin errors++; $display("FAIL two_word_flags got=%b exp=0010", {o_cpu_rst, o_busy, o_done, o_err}); end
    checks++; if (o_word_count !== 16'd2) begin errors++; $display("FAIL two_word_count got=%0d exp=2", o_word_count); end
    checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL two_word_ready got=%0h exp=0", o_rx_ready); end
`ifdef Z16_LOADER_CHECKSUM_EN
    pulse_reload();
    send(8'h02); send(8'h00); send(8'h10); send(8'h00); send(8'h19); send(8'h01); send(8'h2B);
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b1001) begin errors++; $display("FAIL bad_chk_flags got=%b exp=1001", {o_cpu_rst, o_busy, o_done, o_err}); end
`endif
  endtask

  task automatic test_oversize();
    pulse_reload();
    clear_log();
    send(8'h11); send(8'h00);
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b1001) begin errors++; $display("FAIL oversize_flags got=%b exp=1001", {o_cpu_rst, o_busy, o_done, o_err}); end
    checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL oversize_ready got=%0h exp=0", o_rx_ready); end
    tick();
    checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL oversize_writes got=%0d exp=0", wq_addr.size()); end
  endtask

  task automatic test_zero_len();
    pulse_reload();
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b1100) begin errors++; $display("FAIL reload_from_err got=%b exp=1100", {o_cpu_rst, o_busy, o_done, o_err}); end
    clear_log();
    send(8'h00); send(8'h00);
`ifdef Z16_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    tick();
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b0010) begin errors++; $display("FAIL zero_flags got=%b exp=0010", {o_cpu_rst, o_busy, o_done, o_err}); end
    checks++; if (o_word_count !== 16'd0) begin errors++; $display("FAIL zero_count got=%0d exp=0", o_word_count); end
    checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", wq_addr.size()); end
  endtask

  task automatic test_gaps();
    logic [7:0]  b[6];
    logic [15:0] ea;
    logic [15:0] ed;
    b = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h19, 8'h01};
    pulse_reload();
    for (int i = 0; i < 6; i++) begin
      send(b[i]);
      ea = (i == 3) ? 16'h0000 : 16'h0002;
      ed = (i == 3) ? 16'h0010 : 16'h0119;
      if (i == 3 || i == 5) begin
        checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, ea, ed}) begin errors++; $display("FAIL gap_strobe%0d got=%0h exp=%0h", i, {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, ea, ed}); end
      end
      for (int g = 0; g < i % 4; g++) begin
        tick();
        if (g == 0 && (i == 3 || i == 5)) begin
          checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL gap_strobe_len%0d got=%0h exp=0", i, o_wr_en); end
        end
      end
    end
`ifdef Z16_LOADER_CHECKSUM_EN
    send(8'h2A);
`endif
    i_rx_data  = 8'h55;
    i_rx_valid = 1'b1;
    #1;
    checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL done_ready_valid got=%0h exp=0", o_rx_ready); end
    tick();
    tick();
    i_rx_valid = 1'b0;
    checks++; if ({o_done, o_wr_en, o_word_count} !== {1'b1, 1'b0, 16'd2}) begin errors++; $display("FAIL done_stable got=%0h exp=%0h", {o_done, o_wr_en, o_word_count}, {1'b1, 1'b0, 16'd2}); end
  endtask

  task automatic test_reset_mid();
    pulse_reload();
    send(8'h03); send(8'h00); send(8'h10); send(8'h00); send(8'h19); send(8'h01);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++; if ({o_rx_ready, o_cpu_rst, o_busy, o_done, o_err} !== 5'b11100) begin errors++; $display("FAIL mid_reset_flags got=%b exp=11100", {o_rx_ready, o_cpu_rst, o_busy, o_done, o_err}); end
    checks++; if (o_word_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", o_word_count); end
    send(8'h01); send(8'h00); send(8'h40); send(8'h00);
    checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 16'h0000, 16'h0040}) begin errors++; $display("FAIL mid_reset_write got=%0h exp=%0h", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 16'h0000, 16'h0040}); end
`ifdef Z16_LOADER_CHECKSUM_EN
    send(8'h40);
`endif
    checks++; if ({o_done, o_word_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL mid_reset_done got=%0h exp=%0h", {o_done, o_word_count}, {1'b1, 16'd1}); end
  endtask

  task automatic test_reload();
    logic [7:0] sum;
    sum = 8'h00;
    pulse_reload();
    checks++; if ({o_cpu_rst, o_busy, o_done, o_err} !== 4'b1100) begin errors++; $display("FAIL reload_flags got=%b exp=1100", {o_cpu_rst, o_busy, o_done, o_err}); end
    clear_log();
    send(8'h10); send(8'h00);
    for (int i = 0; i < 16; i++) begin
      send(8'(8'hA0 + i));
      send(8'(i));
      sum = sum + 8'(8'hA0 + i) + 8'(i);
      if (i == 5) begin
        pulse_reload();
        checks++; if ({o_busy, o_cpu_rst, o_word_count} !== {1'b1, 1'b1, 16'd6}) begin errors++; $display("FAIL reload_ignored got=%0h exp=%0h", {o_busy, o_cpu_rst, o_word_count}, {1'b1, 1'b1, 16'd6}); end
      end
    end
`ifdef Z16_LOADER_CHECKSUM_EN
    send(sum);
`endif
    tick();
    checks++; if ({o_done, o_cpu_rst, o_word_count} !== {1'b1, 1'b0, 16'd16}) begin errors++; $display("FAIL reload_done got=%0h exp=%0h", {o_done, o_cpu_rst, o_word_count}, {1'b1, 1'b0, 16'd16}); end
    checks++; if (wq_addr.size() !== 16) begin errors++; $display("FAIL reload_nwrites got=%0d exp=16", wq_addr.size()); end
    for (int i = 0; i < 16 && i < wq_addr.size(); i++) begin
      checks++; if ({wq_addr[i], wq_data[i]} !== {16'(2 * i), 8'(i), 8'(8'hA0 + i)}) begin errors++; $display("FAIL reload_write%0d got=%0h exp=%0h", i, {wq_addr[i], wq_data[i]}, {16'(2 * i), 8'(i), 8'(8'hA0 + i)}); end
    end
  endtask

  task automatic test_back_to_back();
    checks++; if (consec !== 0) begin errors++; $display("FAIL strobe_consecutive got=%0d exp=0", consec); end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_reload   = 1'b0;
    test_reset();
    test_two_word();
    test_oversize();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    test_reload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z16_instr_loader.md
Name: z16_instr_loader

Overview:
- Writer side of the Z16 instruction memory: fills a RAM-backed instruction store from a byte stream, typically a UART receiver, instead of relying on hard-coded contents.
- Assembles little-endian 16-bit instruction words and issues single-cycle write strobes on the instruction memory's byte-addressed write port (word index = addr[15:1]).
- Holds the Z16 core in reset until the image is fully written, then releases it.

Parameters:
- DEPTH_WORDS, 16, capacity of the instruction store in 16-bit words; larger lengths are rejected.
- LEN_W, 16, width of the word-count header and of o_word_count.

Ports:
- i_clk  input  1  system clock, all logic rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rx_data  input  8  incoming byte.
- i_rx_valid  input  1  i_rx_data is valid this cycle.
- o_rx_ready  output  1  loader can accept a byte; transfer occurs on i_rx_valid && o_rx_ready.
- i_reload  input  1  single-cycle request to start a new load; honoured only in DONE or ERROR.
- o_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- o_wr_addr  output  16  byte address of the word being written; always even.
- o_wr_data  output  16  instruction word, {high byte, low byte}.
- o_cpu_rst  output  1  reset for the Z16 core, high while loading or in error.
- o_busy  output  1  load in progress.
- o_done  output  1  image loaded successfully; level, not pulse.
- o_err  output  1  load aborted; level.
- o_word_count  output  LEN_W  words written so far in the current load.

Behaviour:
- Reset values: state LEN_LO, o_rx_ready=1, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_cpu_rst=1, o_busy=1, o_done=0, o_err=0, o_word_count=0.
- Stream format: LEN low byte, LEN high byte, then LEN words sent low byte first. The optional checksum byte follows the data.
- States and transitions:
  - LEN_LO: on accept, latch len[7:0]; go to LEN_HI.
  - LEN_HI: on accept, form len. If len > DEPTH_WORDS, go to ERROR. If len == 0, go to DONE (or CHK if enabled). Otherwise go to DATA_LO.
  - DATA_LO: on accept, latch the low byte; go to DATA_HI.
  - DATA_HI: on accept, register o_wr_data={byte, low}, o_wr_addr={o_word_count,1'b0}, o_wr_en=1.
    - Increment o_word_count on the same edge.
    - If the new count == len, go to DONE (or CHK); otherwise go to DATA_LO.
  - DONE: o_rx_ready=0, o_busy=0, o_done=1, o_cpu_rst=0.
  - ERROR: o_rx_ready=0, o_busy=0, o_err=1, o_cpu_rst=1.
- Write timing:
  - o_wr_en is registered. The high byte accepted at edge k gives o_wr_en=1 during cycle k..k+1 only.
  - o_wr_en is never high in two consecutive cycles (at least two accepts per word).
  - o_wr_addr and o_wr_data are held after the strobe until the next write.
- o_rx_ready is high in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK, and is combinational from state only. Gaps in i_rx_valid stall the FSM with no side effects.
- i_reload in DONE/ERROR:
  - Next state LEN_LO; o_word_count, o_done and o_err cleared; o_cpu_rst reasserted; o_busy=1.
  - The previous memory contents are not erased.
  - In any other state i_reload is ignored.
- Word counter and addressing: count is LEN_W bits wide; len ≤ DEPTH_WORDS guarantees o_wr_addr never wraps.
- Reset mid-load: returns to the reset state on the next edge. Any strobe pending that cycle is dropped. Words already written stay in memory. The core stays held in reset.

Optional Feature:
- Macro: Z16_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or directly after LEN_HI when len == 0), enter CHK and accept one byte.
  - If that byte equals the 8-bit modulo-256 sum of all data bytes (header excluded), go to DONE; otherwise go to ERROR.
  - The sum is cleared in LEN_LO.
  - In the error case all words have already been written, but o_cpu_rst stays high.
- Undefined: no CHK state and no accumulator; the stream ends after the last data byte.

Test Plan:
- Two-word load: bytes 02 00 10 00 19 01 -> writes (0x0000, 0x0010) then (0x0002, 0x0119), one-cycle strobes, then o_done=1, o_cpu_rst=0, o_word_count=2. With CHECKSUM_EN, append 2A -> done; append 2B -> o_err=1, o_cpu_rst=1.
- Oversize header: bytes 11 00 (len=17, DEPTH_WORDS=16) -> ERROR right after the second byte, no o_wr_en, o_rx_ready=0.
- Zero length: bytes 00 00 -> DONE (or CHK expecting 00), no writes, o_word_count=0.
- Valid gaps: the two-word stream with 0–3 idle cycles between bytes -> identical writes, strobe exactly one cycle after each high-byte accept; check that o_rx_ready stays 0 in DONE even when i_rx_valid=1.
- Reset mid-load: after 03 00 10 00 19 01, pulse i_rst -> state LEN_LO, count 0, o_cpu_rst=1. A fresh stream 01 00 40 00 writes (0x0000, 0x0040).
- Reload: in DONE, pulse i_reload -> o_cpu_rst=1, o_done=0, o_busy=1. A new image of 16 words writes addresses 0x0000..0x001E. i_reload pulsed mid-load is ignored.
